mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port and a load/store port. At most one access is in flight. A two-state
// FSM (IDLE/WAIT) grants in IDLE, counts MEM_LAT cycles in WAIT, then captures
// the memory read data and pulses the owner's rvalid for one cycle.
//
// Handshake: a requester raises req with its payload and holds both stable
// until it sees gnt in the same cycle; gnt is combinational and only ever
// asserted while the FSM is IDLE and reset is released. Dropping req before
// gnt withdraws the request with no side effect. Each accepted request
// produces exactly one rvalid pulse on the granted side (writes included, as
// a completion ack). rdata is qualified only by that side's rvalid and holds
// until the next response is captured.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  res_n,
  // fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,
  // load/store port
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [3:0]            ls_be,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [31:0]           ls_rdata,
  // memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  // debug: current FSM state (0 = IDLE, 1 = WAIT)
  output logic                  dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Counter reload value; MEM_LAT is restricted to 1..15 so it fits 4 bits.
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  state_e      state;
  logic [3:0]  cnt;
  logic        owner_ls;   // 1: load/store owns the outstanding access
  logic        prio_ls;    // 1: load/store wins a conflict
  logic [31:0] resp;       // shared response register

  logic        both_req;
  logic        grant;
  logic        pick_ls;

  // Arbitration and memory command mux for the grant cycle.
  always_comb begin
    both_req  = if_req && ls_req;
    // res_n gates the grant so nothing leaks out while reset is held.
    grant     = res_n && (state == IDLE) && (if_req || ls_req);
    pick_ls   = ls_req && (!if_req || prio_ls);
    if_gnt    = grant && !pick_ls;
    ls_gnt    = grant && pick_ls;
    mem_en    = grant;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (ls_gnt) begin
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      // fetches are always full-word reads
      mem_we    = 1'b0;
      mem_be    = 4'hF;
      mem_addr  = if_addr;
      mem_wdata = 32'h0;
    end
  end

  // Access FSM: grant in IDLE, count latency in WAIT, capture and ack.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner_ls  <= 1'b0;
      prio_ls   <= 1'b1;
      resp      <= 32'h0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner_ls <= pick_ls;
            cnt      <= LAT_LOAD;
            state    <= WAIT;
            // only a real conflict flips priority, so lone requesters
            // never steal the next turn from the other side
            if (both_req) begin
              prio_ls <= !prio_ls;
            end
          end
        end
        WAIT: begin
          // cnt <= 1 also catches the unreachable zero case safely
          if (cnt <= 4'd1) begin
            cnt       <= 4'd0;
            resp      <= mem_rdata;
            if_rvalid <= !owner_ls;
            ls_rvalid <= owner_ls;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = resp;
  assign ls_rdata  = resp;
  assign dbg_state = (state == WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with
// its own behavioural memory and an expected-response queue filled at grant
// time and drained when rvalid appears. Directed steps run in one initial.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int W  = 50; // {ls, we, due_cycle[15:0], data[31:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res_n;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // instance a: MEM_LAT = 1
  logic          a_if_req, a_if_gnt, a_if_rvalid;
  logic [AW-1:0] a_if_addr;
  logic [31:0]   a_if_rdata;
  logic          a_ls_req, a_ls_we, a_ls_gnt, a_ls_rvalid;
  logic [3:0]    a_ls_be;
  logic [AW-1:0] a_ls_addr;
  logic [31:0]   a_ls_wdata, a_ls_rdata;
  logic          a_mem_en, a_mem_we, a_dbg;
  logic [3:0]    a_mem_be;
  logic [AW-1:0] a_mem_addr;
  logic [31:0]   a_mem_wdata, a_mem_rdata;

  // instance b: MEM_LAT = 3
  logic          b_if_req, b_if_gnt, b_if_rvalid;
  logic [AW-1:0] b_if_addr;
  logic [31:0]   b_if_rdata;
  logic          b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid;
  logic [3:0]    b_ls_be;
  logic [AW-1:0] b_ls_addr;
  logic [31:0]   b_ls_wdata, b_ls_rdata;
  logic          b_mem_en, b_mem_we, b_dbg;
  logic [3:0]    b_mem_be;
  logic [AW-1:0] b_mem_addr;
  logic [31:0]   b_mem_wdata, b_mem_rdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .MEM_LAT(1)) dut_a (
    .clk(clk), .res_n(res_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_be(a_ls_be), .ls_addr(a_ls_addr),
    .ls_wdata(a_ls_wdata), .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid),
    .ls_rdata(a_ls_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .dbg_state(a_dbg)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .MEM_LAT(3)) dut_b (
    .clk(clk), .res_n(res_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_be(b_ls_be), .ls_addr(b_ls_addr),
    .ls_wdata(b_ls_wdata), .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid),
    .ls_rdata(b_ls_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .dbg_state(b_dbg)
  );

  // ---------------- memory models ----------------
  logic [31:0] a_mem [0:63];
  logic [31:0] b_mem [0:63];
  logic [31:0] a_rd = 32'h0;
  logic [31:0] b_rd = 32'h0;
  logic [3:0]  a_age = 4'd0;
  logic [3:0]  b_age = 4'd0;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      1:       return 32'h00500093;
      6:       return 32'h11223344;
      default: return 32'hA5000000 | (32'(i) * 32'h00010101);
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) begin
        a_mem[i] <= init_word(i);
        b_mem[i] <= init_word(i);
      end
    end else begin
      if (a_mem_en) begin
        a_rd  <= a_mem[a_mem_addr[7:2]];
        if (a_mem_we) a_mem[a_mem_addr[7:2]] <= merge(a_mem[a_mem_addr[7:2]], a_mem_wdata, a_mem_be);
        a_age <= 4'd1;
      end else if (a_age != 4'd0 && a_age != 4'hF) a_age <= a_age + 4'd1;
      if (b_mem_en) begin
        b_rd  <= b_mem[b_mem_addr[7:2]];
        if (b_mem_we) b_mem[b_mem_addr[7:2]] <= merge(b_mem[b_mem_addr[7:2]], b_mem_wdata, b_mem_be);
        b_age <= 4'd1;
      end else if (b_age != 4'd0 && b_age != 4'hF) b_age <= b_age + 4'd1;
    end
  end

  // read data is garbage until the configured latency has elapsed
  assign a_mem_rdata = (a_age >= 4'd1) ? a_rd : 32'hDEADBEEF;
  assign b_mem_rdata = (b_age >= 4'd3) ? b_rd : 32'hDEADBEEF;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];

  task automatic sb_step(input bit sel, input logic if_rv, input logic ls_rv,
                         input logic [31:0] if_rd, input logic [31:0] ls_rd,
                         input logic if_g, input logic ls_g, input logic we,
                         input logic [31:0] word, input int lat);
    logic [W-1:0] e;
    string        p;
    p = sel ? "b" : "a";
    if (if_rv || ls_rv) begin
      if ((sel ? b_q.size() : a_q.size()) == 0) begin
        chk({p, "_sb_spurious_rvalid"}, {62'b0, ls_rv, if_rv}, 64'd0);
      end else begin
        if (sel) e = b_q.pop_front();
        else     e = a_q.pop_front();
        chk({p, "_sb_side"}, {62'b0, ls_rv, if_rv}, {62'b0, e[49], ~e[49]});
        chk({p, "_sb_cycle"}, 64'(cyc[15:0]), 64'(e[47:32]));
        if (!e[48]) chk({p, "_sb_data"}, 64'(ls_rv ? ls_rd : if_rd), 64'(e[31:0]));
        chk({p, "_sb_rdata_shared"}, 64'(if_rd), 64'(ls_rd));
      end
    end
    if (if_g || ls_g) begin
      e = {ls_g, we, 16'(cyc + 32'(lat) + 1), (we ? 32'h0 : word)};
      if (sel) b_q.push_back(e);
      else     a_q.push_back(e);
    end
  endtask

  // monitor away from the active edge
  always @(negedge clk) begin
    if (res_n) begin
      sb_step(1'b0, a_if_rvalid, a_ls_rvalid, a_if_rdata, a_ls_rdata, a_if_gnt, a_ls_gnt,
              a_mem_we, a_mem[a_mem_addr[7:2]], 1);
      sb_step(1'b1, b_if_rvalid, b_ls_rvalid, b_if_rdata, b_ls_rdata, b_if_gnt, b_ls_gnt,
              b_mem_we, b_mem[b_mem_addr[7:2]], 3);
    end
  end

  // an aborted access must never respond
  always @(negedge res_n) begin
    a_q.delete();
    b_q.delete();
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic prio_ls;
  logic exp_ls;

  initial begin
    res_n = 1'b0;
    a_if_req = 1'b1; a_if_addr = '0; a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_be = 4'hF;
    a_ls_addr = '0; a_ls_wdata = 32'h0;
    b_if_req = 1'b1; b_if_addr = '0; b_ls_req = 1'b1; b_ls_we = 1'b0; b_ls_be = 4'hF;
    b_ls_addr = '0; b_ls_wdata = 32'h0;
    tick(); tick(); #1;

    // reset with both requests pending
    chk("rst_a_if_gnt", 64'(a_if_gnt), 64'd0);
    chk("rst_a_ls_gnt", 64'(a_ls_gnt), 64'd0);
    chk("rst_a_mem_en", 64'(a_mem_en), 64'd0);
    chk("rst_a_rvalid", {62'b0, a_if_rvalid, a_ls_rvalid}, 64'd0);
    chk("rst_a_rdata", {a_if_rdata, a_ls_rdata}, 64'd0);
    chk("rst_a_state", 64'(a_dbg), 64'd0);
    chk("rst_b_gnt", {62'b0, b_if_gnt, b_ls_gnt}, 64'd0);
    chk("rst_b_mem_en", 64'(b_mem_en), 64'd0);

    a_if_req = 1'b0; a_ls_req = 1'b0; b_if_req = 1'b0; b_ls_req = 1'b0;
    tick(); res_n = 1'b1;
    tick();

    // single fetch, MEM_LAT=1
    tick(); a_if_req = 1'b1; a_if_addr = 8'h04; #1;
    chk("f_if_gnt", 64'(a_if_gnt), 64'd1);
    chk("f_ls_gnt", 64'(a_ls_gnt), 64'd0);
    chk("f_mem_en", 64'(a_mem_en), 64'd1);
    chk("f_mem_we", 64'(a_mem_we), 64'd0);
    chk("f_mem_be", 64'(a_mem_be), 64'hF);
    chk("f_mem_addr", 64'(a_mem_addr), 64'h04);
    chk("f_mem_wdata", 64'(a_mem_wdata), 64'd0);
    tick(); a_if_req = 1'b0; a_ls_req = 1'b1; a_ls_addr = 8'h10; #1;
    chk("wait_ls_gnt", 64'(a_ls_gnt), 64'd0);
    chk("wait_mem_en", 64'(a_mem_en), 64'd0);
    chk("wait_if_rvalid", 64'(a_if_rvalid), 64'd0);
    chk("wait_state", 64'(a_dbg), 64'd1);
    a_ls_req = 1'b0;
    tick(); #1;
    chk("f_if_rvalid", 64'(a_if_rvalid), 64'd1);
    chk("f_if_rdata", 64'(a_if_rdata), 64'h00500093);
    chk("f_ls_rvalid", 64'(a_ls_rvalid), 64'd0);
    chk("f_withdrawn_mem_en", 64'(a_mem_en), 64'd0);

    // both requesting from reset release: ls, if, ls, if
    tick(); res_n = 1'b0;
    a_if_req = 1'b1; a_ls_req = 1'b1; a_if_addr = 8'h0C; a_ls_addr = 8'h08; a_ls_we = 1'b0;
    tick(); tick(); res_n = 1'b1;
    prio_ls = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin a_if_req = 1'b0; a_ls_req = 1'b0; end
      #1;
      if (k % 2 == 0) begin
        exp_ls  = prio_ls;
        prio_ls = !prio_ls;
        chk($sformatf("alt_ls_gnt_%0d", k), 64'(a_ls_gnt), 64'(exp_ls));
        chk($sformatf("alt_if_gnt_%0d", k), 64'(a_if_gnt), 64'(!exp_ls));
      end else begin
        chk($sformatf("alt_nognt_%0d", k), {62'b0, a_if_gnt, a_ls_gnt}, 64'd0);
      end
      tick();
    end
    #1;
    chk("alt_last_if_rvalid", {62'b0, a_if_rvalid, a_ls_rvalid}, 64'b10);

    // store on ls while fetch waits
    tick();
    a_ls_req = 1'b1; a_ls_we = 1'b1; a_ls_be = 4'b0011; a_ls_addr = 8'h18;
    a_ls_wdata = 32'h0000002A; a_if_req = 1'b1; a_if_addr = 8'h18; #1;
    chk("st_ls_gnt", 64'(a_ls_gnt), 64'd1);
    chk("st_if_gnt", 64'(a_if_gnt), 64'd0);
    chk("st_mem_we", 64'(a_mem_we), 64'd1);
    chk("st_mem_be", 64'(a_mem_be), 64'b0011);
    chk("st_mem_wdata", 64'(a_mem_wdata), 64'h2A);
    chk("st_mem_addr", 64'(a_mem_addr), 64'h18);
    tick(); a_ls_req = 1'b0; a_ls_we = 1'b0; a_ls_be = 4'hF; #1;
    chk("st_wait_if_gnt", 64'(a_if_gnt), 64'd0);
    tick(); #1;
    chk("st_ack", {62'b0, a_if_rvalid, a_ls_rvalid}, 64'b01);
    chk("st_then_if_gnt", 64'(a_if_gnt), 64'd1);
    chk("st_then_mem_we", 64'(a_mem_we), 64'd0);
    tick(); a_if_req = 1'b0;
    tick(); #1;
    chk("st_readback", 64'(a_if_rdata), 64'h1122002A);
    chk("st_readback_rvalid", 64'(a_if_rvalid), 64'd1);

    // reset one cycle into a load's WAIT
    tick(); a_ls_req = 1'b1; a_ls_addr = 8'h20; #1;
    chk("ab_ls_gnt", 64'(a_ls_gnt), 64'd1);
    tick(); a_ls_req = 1'b0; res_n = 1'b0; #1;
    chk("ab_state", 64'(a_dbg), 64'd0);
    chk("ab_rvalid_in_rst", 64'(a_ls_rvalid), 64'd0);
    res_n = 1'b1;
    tick(); #1;
    chk("ab_no_rvalid_1", 64'(a_ls_rvalid), 64'd0);
    tick(); #1;
    chk("ab_no_rvalid_2", 64'(a_ls_rvalid), 64'd0);
    a_ls_req = 1'b1; a_if_req = 1'b1; a_if_addr = 8'h24; #1;
    chk("ab_reissue_ls_gnt", 64'(a_ls_gnt), 64'd1);
    chk("ab_reissue_if_gnt", 64'(a_if_gnt), 64'd0);
    tick(); a_ls_req = 1'b0; a_if_req = 1'b0;
    tick(); #1;
    chk("ab_reissue_rvalid", 64'(a_ls_rvalid), 64'd1);
    chk("ab_reissue_rdata", 64'(a_ls_rdata), 64'(init_word(8)));

    // MEM_LAT=3 back-to-back fetches
    tick(); b_if_req = 1'b1; b_if_addr = 8'h04;
    for (int k = 0; k <= 12; k++) begin
      if (k == 9) b_if_req = 1'b0;
      #1;
      chk($sformatf("lat3_if_gnt_%0d", k), 64'(b_if_gnt), 64'((k % 4 == 0) && (k <= 8)));
      chk($sformatf("lat3_if_rvalid_%0d", k), 64'(b_if_rvalid), 64'((k % 4 == 0) && (k >= 4)));
      tick();
    end

    tick(); tick(); tick();
    chk("a_queue_drained", 64'(a_q.size()), 64'd0);
    chk("b_queue_drained", 64'(b_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
